// File: rtl/lbs_pkg.sv
// Shared types and constants for the local-bus master and the blocks it drives.
package lbs_pkg;

    localparam int LBS_AW = 16;
    localparam int LBS_DW = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DRAIN = 2'd3
    } lbs_state_e;

    // Register map of the converter top reached over this bus
    localparam logic [LBS_AW-1:0] ADDR_DUC_CMD = 16'd16000;
    localparam logic [LBS_AW-1:0] ADDR_RX_SEL  = 16'd16001;
    localparam logic [LBS_AW-1:0] ADDR_TX_SEL  = 16'd16002;
    localparam logic [LBS_AW-1:0] ADDR_LED     = 16'd16003;

endpackage

// File: rtl/lbs_rd_pipe.sv
// Read-return tracker: RD_LAT+1 deep valid/last delay line with a capture register
// that samples the slave data RD_LAT cycles after each read strobe.
module lbs_rd_pipe
    import lbs_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              re_i,
    input  logic              last_i,
    input  logic [LBS_DW-1:0] dout_i,
    output logic              pend_nxt_o,
    output logic              rd_valid_o,
    output logic              rd_last_o,
    output logic [LBS_DW-1:0] rd_data_o
);

    logic [RD_LAT:0]   vld_q, vld_d;
    logic [RD_LAT:0]   lst_q, lst_d;
    logic [LBS_DW-1:0] data_q;

    always_comb begin
        vld_d = {vld_q[RD_LAT-1:0], re_i};
        lst_d = {lst_q[RD_LAT-1:0], re_i & last_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q  <= '0;
            lst_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q <= vld_d;
            lst_q <= lst_d;
            // Slave data is valid in the cycle just before the output stage
            if (vld_q[RD_LAT-1]) data_q <= dout_i;
        end
    end

    // Lets the master decide IDLE/cmd_ready from the pipeline's next contents
    assign pend_nxt_o = |vld_d;
    assign rd_valid_o = vld_q[RD_LAT];
    assign rd_last_o  = lst_q[RD_LAT];
    assign rd_data_o  = data_q;

endmodule

// File: rtl/lbs_master.sv
// Local-bus master: turns a command + write-data stream into lbs_* bus cycles and
// returns read data. The write-stall abort is compiled in with LBS_MASTER_TIMEOUT_EN.
//   state    | meaning
//   IDLE     | waiting for a command (and for reads to drain)
//   WRITE    | one bus write per write-data handshake
//   RD_ISSUE | one bus read per cycle, no gaps
//   RD_DRAIN | all reads issued, waiting for the return pipeline to empty
module lbs_master
    import lbs_pkg::*;
#(
    parameter int U_DLY       = 1,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              lbs_clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [LBS_AW-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic              wr_valid,
    input  logic [LBS_DW-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [LBS_DW-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              err_timeout,
    output logic [LBS_AW-1:0] lbs_addr,
    output logic [LBS_DW-1:0] lbs_din,
    output logic              lbs_we,
    output logic              lbs_re,
    input  logic [LBS_DW-1:0] lbs_dout
);

    // U_DLY only matters to delay-annotated simulation models; no delays are used here
    if (RD_LAT < 1 || RD_LAT > 4 || TIMEOUT_CYC < 1 || U_DLY < 0) begin : g_bad_param
        $error("lbs_master: illegal parameter value");
    end

    lbs_state_e        state_q, state_d;
    logic [LBS_AW-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [LBS_AW-1:0] lbs_addr_q, lbs_addr_d;
    logic [LBS_DW-1:0] lbs_din_q, lbs_din_d;
    logic              lbs_we_q, lbs_we_d, lbs_re_q, lbs_re_d;
    logic              re_last_q, re_last_d;
    logic              cmd_ready_q, cmd_ready_d, wr_ready_q, wr_ready_d, busy_q, busy_d;
    logic              accept, wr_hs, pend_nxt, timeout_hit;

    assign accept = cmd_valid & cmd_ready_q;
    assign wr_hs  = wr_valid & wr_ready_q;

    always_ff @(posedge lbs_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (accept) state_d = cmd_wr ? WRITE : RD_ISSUE;
            WRITE:    if ((wr_hs && cnt_q == 8'd0) || timeout_hit) state_d = IDLE;
            RD_ISSUE: if (cnt_q == 8'd0) state_d = RD_DRAIN;
            RD_DRAIN: if (!pend_nxt) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        lbs_addr_d = lbs_addr_q;
        lbs_din_d  = lbs_din_q;
        lbs_we_d   = 1'b0;
        lbs_re_d   = 1'b0;
        re_last_d  = 1'b0;
        unique case (state_q)
            IDLE: if (accept) begin
                addr_d = cmd_addr;
                cnt_d  = cmd_len;
            end
            WRITE: if (wr_hs) begin
                lbs_we_d   = 1'b1;
                lbs_addr_d = addr_q;
                lbs_din_d  = wr_data;
                addr_d     = addr_q + 16'd1;
                cnt_d      = cnt_q - 8'd1;
            end
            RD_ISSUE: begin
                lbs_re_d   = 1'b1;
                lbs_addr_d = addr_q;
                re_last_d  = (cnt_q == 8'd0);
                addr_d     = addr_q + 16'd1;
                cnt_d      = cnt_q - 8'd1;
            end
            default: ;
        endcase
        cmd_ready_d = (state_d == IDLE) & ~pend_nxt;
        wr_ready_d  = (state_d == WRITE);
        busy_d      = (state_d != IDLE) | pend_nxt;
    end

    always_ff @(posedge lbs_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            cnt_q       <= '0;
            lbs_addr_q  <= '0;
            lbs_din_q   <= '0;
            lbs_we_q    <= 1'b0;
            lbs_re_q    <= 1'b0;
            re_last_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            lbs_addr_q  <= lbs_addr_d;
            lbs_din_q   <= lbs_din_d;
            lbs_we_q    <= lbs_we_d;
            lbs_re_q    <= lbs_re_d;
            re_last_q   <= re_last_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef LBS_MASTER_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);
    logic [SW-1:0] stall_q, stall_d;
    logic          err_q;

    // Down-counter reloaded on every handshake; terminal count aborts the burst
    always_comb begin
        stall_d     = SW'(TIMEOUT_CYC);
        timeout_hit = 1'b0;
        if (state_q == WRITE && !wr_valid) begin
            if (stall_q <= SW'(1)) timeout_hit = 1'b1;
            else                   stall_d     = stall_q - SW'(1);
        end
    end

    always_ff @(posedge lbs_clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= SW'(TIMEOUT_CYC);
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= timeout_hit;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    lbs_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk_i      (lbs_clk),
        .rst_n_i    (rst_n),
        .re_i       (lbs_re_q),
        .last_i     (re_last_q),
        .dout_i     (lbs_dout),
        .pend_nxt_o (pend_nxt),
        .rd_valid_o (rd_valid),
        .rd_last_o  (rd_last),
        .rd_data_o  (rd_data)
    );

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign busy      = busy_q;
    assign lbs_addr  = lbs_addr_q;
    assign lbs_din   = lbs_din_q;
    assign lbs_we    = lbs_we_q;
    assign lbs_re    = lbs_re_q;

endmodule
